// File: rtl/lcd_id_reader_if.sv
// Bus bundle between the panel-ID reader and its environment: RGB readback,
// rescan request, bus drive enable and the resolved panel ID.
interface lcd_id_reader_if;
  logic [23:0] lcd_rgb_in;
  logic        rescan;
  logic        lcd_rgb_oe;
  logic [15:0] id_lcd;
  logic        id_valid;
  logic        id_err;

  modport master (
    output lcd_rgb_in,
    output rescan,
    input  lcd_rgb_oe,
    input  id_lcd,
    input  id_valid,
    input  id_err
  );

  modport slave (
    input  lcd_rgb_in,
    input  rescan,
    output lcd_rgb_oe,
    output id_lcd,
    output id_valid,
    output id_err
  );
endinterface

// File: rtl/lcd_id_reader.sv
// Reads the panel strap pins M2/M1/M0 off the released RGB bus and reports a panel ID.
// Build option LCD_ID_MAJORITY_EN: resolve each ID bit by 2-of-3 vote instead of requiring identical samples.
module lcd_id_reader #(
  parameter logic [15:0] SETTLE_CYC  = 16'd5000,
  parameter logic [15:0] SAMPLE_GAP  = 16'd500,
  parameter logic [1:0]  SAMPLE_NUM  = 2'd3,
  parameter logic [1:0]  RETRY_MAX   = 2'd3,
  parameter logic [15:0] FALLBACK_ID = 16'd1
) (
  input  logic           clk,
  input  logic           rst_n,
  lcd_id_reader_if.slave bus
);

  localparam logic [2:0] ST_RELEASE = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_SAMPLE  = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

`ifdef LCD_ID_MAJORITY_EN
  localparam logic [15:0] N_SMP = 16'd3;
`else
  localparam logic [15:0] N_SMP = (SAMPLE_NUM < 2'd2) ? 16'd2 : {14'd0, SAMPLE_NUM};
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]  pin_raw;
  logic [2:0]  sync1_reg, sync2_reg;
  logic [2:0]  state_reg, state_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic [15:0] idx_reg, idx_next;
  logic [15:0] retry_reg, retry_next;
  logic [15:0] id_lcd_reg, id_lcd_next;
  logic        id_valid_reg, id_valid_next;
  logic        id_err_reg, id_err_next;
  logic        oe_reg, oe_next;
  logic [8:0]  slot_flat;
  logic [2:0]  s0, s1, s2, code;
  logic        agree, code_ok, settle_done, gap_done;

  assign pin_raw = {bus.lcd_rgb_in[23], bus.lcd_rgb_in[15], bus.lcd_rgb_in[7]};

  // Strap pins are asynchronous to clk; only sync2_reg is ever consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 3'd0;
      sync2_reg <= 3'd0;
    end else begin
      sync1_reg <= pin_raw;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      logic [2:0] q_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          q_reg <= 3'd0;
        else if (state_reg == ST_SAMPLE && idx_reg == 16'(gi))
          q_reg <= sync2_reg;
      end
      assign slot_flat[gi*3 +: 3] = q_reg;
    end
  endgenerate

  assign s0 = slot_flat[2:0];
  assign s1 = slot_flat[5:3];
  assign s2 = slot_flat[8:6];

  generate
    for (gi = 0; gi < 3; gi++) begin : g_vote
`ifdef LCD_ID_MAJORITY_EN
      assign code[gi] = (s0[gi] & s1[gi]) | (s0[gi] & s2[gi]) | (s1[gi] & s2[gi]);
`else
      assign code[gi] = s0[gi];
`endif
    end
  endgenerate

`ifdef LCD_ID_MAJORITY_EN
  assign agree = 1'b1;
`else
  assign agree = (s0 == s1) && ((N_SMP < 16'd3) || (s2 == s0));
`endif

  // Codes 3, 6 and 7 do not correspond to any supported panel class.
  assign code_ok     = agree && (code != 3'd3) && (code != 3'd6) && (code != 3'd7);
  assign settle_done = ({1'b0, wait_cnt_reg} + 17'd1) >= {1'b0, SETTLE_CYC};
  assign gap_done    = ({1'b0, wait_cnt_reg} + 17'd1) >= {1'b0, SAMPLE_GAP};

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    idx_next      = idx_reg;
    retry_next    = retry_reg;
    id_lcd_next   = id_lcd_reg;
    id_valid_next = id_valid_reg;
    id_err_next   = id_err_reg;
    oe_next       = oe_reg;
    // A rescan while already releasing would only repeat RELEASE, so it is dropped.
    if (bus.rescan && state_reg != ST_RELEASE) begin
      state_next    = ST_RELEASE;
      id_valid_next = 1'b0;
      oe_next       = 1'b0;
      retry_next    = 16'd0;
    end else begin
      case (state_reg)
        ST_RELEASE: begin
          oe_next       = 1'b0;
          idx_next      = 16'd0;
          wait_cnt_next = 16'd0;
          state_next    = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_done) begin
            wait_cnt_next = 16'd0;
            state_next    = ST_SAMPLE;
          end else begin
            wait_cnt_next = sat_inc(wait_cnt_reg);
          end
        end
        ST_SAMPLE: begin
          if (idx_reg < N_SMP - 16'd1) begin
            idx_next      = sat_inc(idx_reg);
            wait_cnt_next = 16'd0;
            state_next    = ST_GAP;
          end else begin
            state_next = ST_CHECK;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            wait_cnt_next = 16'd0;
            state_next    = ST_SAMPLE;
          end else begin
            wait_cnt_next = sat_inc(wait_cnt_reg);
          end
        end
        ST_CHECK: begin
          if (code_ok) begin
            id_lcd_next   = {13'd0, code};
            id_err_next   = 1'b0;
            id_valid_next = 1'b1;
            oe_next       = 1'b1;
            state_next    = ST_DONE;
          end else if (retry_reg < {14'd0, RETRY_MAX}) begin
            retry_next = sat_inc(retry_reg);
            state_next = ST_RELEASE;
          end else begin
            id_lcd_next   = FALLBACK_ID;
            id_err_next   = 1'b1;
            id_valid_next = 1'b1;
            oe_next       = 1'b1;
            state_next    = ST_DONE;
          end
        end
        ST_DONE: begin
          state_next = ST_DONE;
        end
        default: begin
          state_next = ST_RELEASE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RELEASE;
      wait_cnt_reg <= 16'd0;
      idx_reg      <= 16'd0;
      retry_reg    <= 16'd0;
      id_lcd_reg   <= FALLBACK_ID;
      id_valid_reg <= 1'b0;
      id_err_reg   <= 1'b0;
      oe_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      idx_reg      <= idx_next;
      retry_reg    <= retry_next;
      id_lcd_reg   <= id_lcd_next;
      id_valid_reg <= id_valid_next;
      id_err_reg   <= id_err_next;
      oe_reg       <= oe_next;
    end
  end

  assign bus.lcd_rgb_oe = oe_reg;
  assign bus.id_lcd     = id_lcd_reg;
  assign bus.id_valid   = id_valid_reg;
  assign bus.id_err     = id_err_reg;

endmodule
